posit_accum_sched: RTL
======================

Name: posit_accum_sched

Overview:
Round-robin scheduler that shares one pipelined posit accumulator (positaccumulator) among NREQ requester lanes of the PairHMM datapath. Each lane streams a burst of posit operands terminated by a last flag. The scheduler grants one lane at a time and forwards its operands to the accumulator with a registered stage. It then waits for the accumulator's done pulse and returns the tagged result over a valid/ready result port.

Parameters:
N, 32, posit word width
ES, 2, posit exponent size (passed through to package constants)
NREQ, 4, number of requester lanes (>=2)
CW, 8, width of per-burst operand counter
TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with ACCUM_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-lane operand valid
req_data  in  NREQ*N  per-lane operand; lane i at [i*N +: N]
req_last  in  NREQ  per-lane last operand of burst
req_ready  out  NREQ  per-lane operand accepted
acc_start  out  1  first operand of burst; accumulator clears
acc_valid  out  1  operand valid to accumulator
acc_in  out  N  operand to accumulator
acc_last  out  1  final operand of burst
acc_result  in  N  accumulator result
acc_inf  in  1  result is NaR
acc_zero  in  1  result is zero
acc_done  in  1  single-cycle result-valid pulse
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  N  captured result
res_inf  out  1  captured inf flag
res_zero  out  1  captured zero flag
res_id  out  $clog2(NREQ)  granted lane index
res_count  out  CW  operands in burst (saturates at 2^CW-1)
res_err  out  1  timeout flag (0 when feature off)

Behaviour:
- Reset (any cycle, including mid-burst): state=IDLE, rr pointer=0, all outputs 0, counter=0. In-flight burst is abandoned; the accumulator is not informed.
- FSM states: IDLE, STREAM, WAIT, OUTPUT.
- IDLE:
  - If any req_valid, grant = first asserted lane at or after the rr pointer (wrapping). Register grant; go to STREAM next cycle.
  - req_ready is 0 in IDLE.
- STREAM:
  - req_ready[grant] = 1 combinationally; other lanes 0.
  - Each req_valid[grant] beat is registered onto acc_valid/acc_in/acc_last one cycle later (1-cycle latency).
  - acc_start=1 on the first forwarded beat of the burst only.
  - req_valid low means a bubble: acc_valid=0 next cycle, stay in STREAM.
  - Counter increments per beat and saturates.
  - A beat with req_last goes to WAIT; req_ready drops the same cycle the state leaves STREAM.
- WAIT:
  - acc_valid=0.
  - On acc_done, capture acc_result/inf/zero, grant, and count; go to OUTPUT.
  - An acc_done in the same cycle the final operand is presented is legal and captured.
- OUTPUT:
  - res_valid=1; all res_* outputs hold stable until res_ready.
  - On res_valid&&res_ready: rr pointer = grant+1 mod NREQ, counter cleared, go to IDLE.
  - res_valid deasserts the next cycle.
- acc_done outside WAIT/last-beat is ignored.
- Single-beat burst (first beat has last): acc_start=acc_last=1 on that beat.
- Lanes not granted see req_ready=0 and must hold data (AXI-style).
- Exactly one burst is in flight; no new grant until the result handshake completes.

Optional Feature:
ACCUM_TIMEOUT_EN
- Defined: a WAIT cycle counter runs. When it reaches TIMEOUT_CYCLES without acc_done, the block goes to OUTPUT with res_data=NaR (1 followed by N-1 zeros), res_inf=1, res_zero=0, res_err=1. A later stray acc_done is ignored.
- Undefined: WAIT is unbounded and res_err is tied to 0.

Decomposition:
- Package posit_sched_pkg:
  - state enum (IDLE, STREAM, WAIT, OUTPUT)
  - function posit_nar(N)
  - POSIT_ZERO constant
  - ID width helper
- Sub-module rr_arbiter: combinational grant from req vector and pointer, returns one-hot and index. The pointer register stays in posit_accum_sched.

Test Plan:
- Lane0 sends 0x40000000, 0x40000000(last); model returns 0x48000000 -> res_id=0, res_data=0x48000000, res_count=2, acc_start only on beat 1.
- Lanes 0..3 all valid with single-beat bursts -> grants 0,1,2,3,0 in order. The pointer advances only after each res handshake.
- Lane2 burst 0x40000000, bubble 3 cycles, 0x4A000000(last) -> acc_valid has 3 idle cycles, res_count=2, no extra acc_start.
- res_ready held low 10 cycles in OUTPUT -> res_* stable, no new req_ready to any lane.
- reset asserted mid-STREAM after 1 beat -> all outputs 0 immediately. Next burst from lane1 is granted normally with acc_start=1.
- With ACCUM_TIMEOUT_EN and acc_done never asserted -> after 64 WAIT cycles, res_data=0x80000000, res_inf=1, res_err=1.

Source files
------------

// File: rtl/posit_accum_sched_pkg.sv
// Shared constants for the posit accumulator scheduler: FSM encodings,
// posit special values and the lane-index width helper.
package posit_sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_OUTPUT = 2'd3;

    // Widest posit supported; narrower words take the low slice.
    localparam int POSIT_WMAX = 64;
    localparam logic [POSIT_WMAX-1:0] POSIT_ZERO = '0;

    function automatic logic [POSIT_WMAX-1:0] posit_nar(input int n);
        return {{(POSIT_WMAX-1){1'b0}}, 1'b1} << (n - 1);
    endfunction

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/posit_accum_sched_if.sv
// Bundle of requester, accumulator and result signals around the scheduler.
// slave = scheduler view, master = surrounding datapath view.
interface posit_accum_sched_if #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int CW   = 8
) ();
    import posit_sched_pkg::*;

    localparam int IW = id_w(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;

    logic              acc_start;
    logic              acc_valid;
    logic [N-1:0]      acc_in;
    logic              acc_last;
    logic [N-1:0]      acc_result;
    logic              acc_inf;
    logic              acc_zero;
    logic              acc_done;

    logic              res_valid;
    logic              res_ready;
    logic [N-1:0]      res_data;
    logic              res_inf;
    logic              res_zero;
    logic [IW-1:0]     res_id;
    logic [CW-1:0]     res_count;
    logic              res_err;

    modport slave (
        input  req_valid, req_data, req_last,
        input  acc_result, acc_inf, acc_zero, acc_done,
        input  res_ready,
        output req_ready,
        output acc_start, acc_valid, acc_in, acc_last,
        output res_valid, res_data, res_inf, res_zero, res_id, res_count, res_err
    );

    modport master (
        output req_valid, req_data, req_last,
        output acc_result, acc_inf, acc_zero, acc_done,
        output res_ready,
        input  req_ready,
        input  acc_start, acc_valid, acc_in, acc_last,
        input  res_valid, res_data, res_inf, res_zero, res_id, res_count, res_err
    );

endinterface

// File: rtl/posit_accum_sched_rr_arbiter.sv
// Combinational round-robin pick: first requesting lane at or after ptr_i,
// wrapping. The pointer itself lives in the caller.
module rr_arbiter
    import posit_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic found;
    int   lane;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        lane  = 0;
        for (int k = 0; k < NREQ; k++) begin
            lane = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[lane]) begin
                found       = 1'b1;
                gnt_o[lane] = 1'b1;
                idx_o       = IW'(lane);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/posit_accum_sched.sv
// Round-robin scheduler sharing one pipelined posit accumulator among NREQ lanes.
// Optional ACCUM_TIMEOUT_EN: bounded WAIT, NaR result with res_err on expiry.
module posit_accum_sched
    import posit_sched_pkg::*;
#(
    parameter int N              = 32,
    parameter int ES             = 2,
    parameter int NREQ           = 4,
    parameter int CW             = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                clk,
    input logic                reset,
    posit_accum_sched_if.slave bus
);

    localparam int            IW      = id_w(NREQ);
    localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

    if (NREQ < 2 || N < 2 || N > POSIT_WMAX || ES < 0 || CW < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("posit_accum_sched: unsupported parameter set");
    end

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d, ptr_q, ptr_d;
    logic [NREQ-1:0] grant_oh_q, grant_oh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            first_q, first_d;
    logic            acc_start_q, acc_start_d, acc_valid_q, acc_valid_d, acc_last_q, acc_last_d;
    logic [N-1:0]    acc_in_q, acc_in_d;
    logic            res_valid_q, res_valid_d, res_inf_q, res_inf_d, res_zero_q, res_zero_d;
    logic [N-1:0]    res_data_q, res_data_d;
    logic [IW-1:0]   res_id_q, res_id_d;
    logic [CW-1:0]   res_count_q, res_count_d;

    logic [NREQ-1:0] arb_oh;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            in_stream, beat, beat_last, capture;
    logic [N-1:0]    beat_data;
    logic [CW-1:0]   cnt_inc;

`ifdef ACCUM_TIMEOUT_EN
    localparam int                        TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [POSIT_WMAX-1:0]     NAR_WIDE = posit_nar(N);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          res_err_q, res_err_d;
`endif

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_oh),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign in_stream = (state_q == ST_STREAM);
    assign beat      = in_stream && |(bus.req_valid & grant_oh_q);
    assign beat_last = bus.req_last[grant_q];
    assign beat_data = bus.req_data[int'(grant_q)*N +: N];
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_oh_d  = grant_oh_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        acc_start_d = 1'b0;
        acc_valid_d = 1'b0;
        acc_last_d  = 1'b0;
        acc_in_d    = acc_in_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_inf_d   = res_inf_q;
        res_zero_d  = res_zero_q;
        res_id_d    = res_id_q;
        res_count_d = res_count_q;
        capture     = 1'b0;
`ifdef ACCUM_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        res_err_d   = res_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d    = arb_idx;
                    grant_oh_d = arb_oh;
                    first_d    = 1'b1;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
`ifdef ACCUM_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                if (beat) begin
                    acc_valid_d = 1'b1;
                    acc_start_d = first_q;
                    acc_last_d  = beat_last;
                    acc_in_d    = beat_data;
                    first_d     = 1'b0;
                    cnt_d       = cnt_inc;
                    if (beat_last) begin
                        state_d = ST_WAIT;
                        capture = bus.acc_done;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.acc_done) begin
                    capture = 1'b1;
                end
`ifdef ACCUM_TIMEOUT_EN
                else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    res_data_d  = NAR_WIDE[N-1:0];
                    res_inf_d   = 1'b1;
                    res_zero_d  = 1'b0;
                    res_err_d   = 1'b1;
                    res_id_d    = grant_q;
                    res_count_d = cnt_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_OUTPUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
`endif
            end
            ST_OUTPUT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    ptr_d       = (grant_q == LAST_ID) ? '0 : grant_q + IW'(1);
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A done pulse coinciding with the closing beat still counts that beat.
        if (capture) begin
            res_data_d  = bus.acc_result;
            res_inf_d   = bus.acc_inf;
            res_zero_d  = bus.acc_zero;
            res_id_d    = grant_q;
            res_count_d = cnt_d;
            res_valid_d = 1'b1;
            state_d     = ST_OUTPUT;
`ifdef ACCUM_TIMEOUT_EN
            res_err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_oh_q  <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            acc_start_q <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_last_q  <= 1'b0;
            acc_in_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= POSIT_ZERO[N-1:0];
            res_inf_q   <= 1'b0;
            res_zero_q  <= 1'b0;
            res_id_q    <= '0;
            res_count_q <= '0;
`ifdef ACCUM_TIMEOUT_EN
            wait_cnt_q  <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_oh_q  <= grant_oh_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            acc_start_q <= acc_start_d;
            acc_valid_q <= acc_valid_d;
            acc_last_q  <= acc_last_d;
            acc_in_q    <= acc_in_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_inf_q   <= res_inf_d;
            res_zero_q  <= res_zero_d;
            res_id_q    <= res_id_d;
            res_count_q <= res_count_d;
`ifdef ACCUM_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    assign bus.req_ready = in_stream ? grant_oh_q : '0;
    assign bus.acc_start = acc_start_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.acc_last  = acc_last_q;
    assign bus.acc_in    = acc_in_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_inf   = res_inf_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_count = res_count_q;
`ifdef ACCUM_TIMEOUT_EN
    assign bus.res_err   = res_err_q;
`else
    assign bus.res_err   = 1'b0;
`endif

endmodule
